lcd_bus_writer: RTL and testbench

Parametrised, FIFO-buffered write engine for the character LCD port (lcd_data / lcd_ctrl / lcd_enable) driven by the CPU top.
- Accepts command/data bytes over a valid/ready handshake from the memory-mapped I/O decode.
- Sequences each byte onto the LCD bus with programmable setup/enable/hold/busy timing.
- Supports 8-bit or 4-bit (two-nibble) bus mode.
- Replaces the fixed 8-bit, unbuffered LCD strobe logic.

---
 rtl/lcd_pkg.sv | 35 +++
 rtl/lcd_bus_writer_fifo.sv | 65 ++++++
 rtl/lcd_bus_writer.sv | 189 ++++++++++++++++++
 tb/tb_lcd_bus_writer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the character-LCD write engine.
//   - FSM state encoding (localparams plus the enum built from them)
//   - bit positions inside the {rs, rw} control pair
//   - command codes that need the long post-transfer wait
package lcd_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_PULSE = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        SETUP = ST_SETUP,
        PULSE = ST_PULSE,
        HOLD  = ST_HOLD,
        WAIT  = ST_WAIT
    } lcd_state_t;

    localparam int LCD_CTRL_RS = 1;
    localparam int LCD_CTRL_RW = 0;

    // Clear display is 8'h01; return home is 8'b0000_001x, so masking off
    // bit 0 and comparing against 8'h02 catches both home encodings.
    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_HOME_MASK = 8'hFE;
    localparam logic [7:0] CMD_HOME      = 8'h02;

    // True when the controller needs the long execution time after this entry.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == CMD_CLEAR) || ((data & CMD_HOME_MASK) == CMD_HOME));
    endfunction

endpackage

// File: rtl/lcd_bus_writer_fifo.sv
// sync_fifo: single-clock FIFO with show-ahead read port.
//   clk, rst_n      : clock, asynchronous active-high reset
//   push, push_data : write request and data (ignored when full)
//   pop, pop_data   : read request; pop_data shows the head entry combinationally
//   full, empty     : status decoded from the registered occupancy count
//   count           : number of stored entries
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/lcd_bus_writer.sv
// lcd_bus_writer: FIFO-buffered write engine for a character LCD port.
//   clk, rst_n          : clock, asynchronous active-high reset
//   wr_valid, wr_ready  : write handshake (ready = FIFO not full)
//   wr_rs, wr_data      : register select (0 cmd, 1 data) and byte
//   lcd_data, lcd_ctrl  : LCD bus and {rs, rw}; rw is always 0
//   lcd_enable          : LCD E strobe
//   busy                : FIFO non-empty or a transfer/wait in progress
//   overflow            : sticky, set when a write is offered while not ready
module lcd_bus_writer
    import lcd_pkg::*;
#(
    parameter int BUS_WIDTH    = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int SETUP_CYCLES = 2,
    parameter int PULSE_CYCLES = 4,
    parameter int HOLD_CYCLES  = 2,
    parameter int BUSY_CYCLES  = 40,
    parameter int CLEAR_CYCLES = 1600
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic                 wr_rs,
    input  logic [7:0]           wr_data,
    output logic [BUS_WIDTH-1:0] lcd_data,
    output logic [1:0]           lcd_ctrl,
    output logic                 lcd_enable,
    output logic                 busy,
    output logic                 overflow
);

    if ((BUS_WIDTH != 8) && (BUS_WIDTH != 4)) begin : g_bad_bus_width
        $error("lcd_bus_writer: BUS_WIDTH must be 4 or 8");
    end

    localparam int CW  = $clog2(CLEAR_CYCLES + 1);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);

    // Counter reload values: each phase lasts N cycles, counting N-1 down to 0.
    localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] BUSY_LOAD  = CW'(BUSY_CYCLES - 1);
    localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_CYCLES - 1);

    logic           fifo_full;
    logic           fifo_empty;
    logic [FCW-1:0] fifo_count;
    logic [8:0]     fifo_head;
    logic           fifo_pop;
    logic           push;

    lcd_state_t           state, state_d;
    logic [CW-1:0]        cnt, cnt_d;
    logic                 lat_rs, lat_rs_d;
    logic [7:0]           lat_data, lat_data_d;
    logic                 second_pending, second_pending_d;
    logic [BUS_WIDTH-1:0] lcd_data_d;
    logic [1:0]           lcd_ctrl_d;
    logic                 lcd_enable_d;

    assign wr_ready = !fifo_full;
    assign push     = wr_valid && wr_ready;
    assign busy     = (state != IDLE) || (fifo_count != '0);

    sync_fifo #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({wr_rs, wr_data}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Rejected writes are dropped; the flag stays set until reset.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            overflow <= 1'b0;
        end else if (wr_valid && !wr_ready) begin
            overflow <= 1'b1;
        end
    end

    // State register; async reset drops E immediately and abandons any entry.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            lat_rs         <= 1'b0;
            lat_data       <= 8'h00;
            second_pending <= 1'b0;
            lcd_data       <= '0;
            lcd_ctrl       <= 2'b00;
            lcd_enable     <= 1'b0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            lat_rs         <= lat_rs_d;
            lat_data       <= lat_data_d;
            second_pending <= second_pending_d;
            lcd_data       <= lcd_data_d;
            lcd_ctrl       <= lcd_ctrl_d;
            lcd_enable     <= lcd_enable_d;
        end
    end

    // Next-state logic. Bus values persist by default so WAIT/IDLE hold
    // the last beat. In 4-bit mode the high nibble goes first and the low
    // nibble is queued as a second beat through another SETUP/PULSE/HOLD.
    always_comb begin
        state_d          = state;
        cnt_d            = cnt;
        lat_rs_d         = lat_rs;
        lat_data_d       = lat_data;
        second_pending_d = second_pending;
        lcd_data_d       = lcd_data;
        lcd_ctrl_d       = lcd_ctrl;
        lcd_enable_d     = lcd_enable;
        fifo_pop         = 1'b0;

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop                = 1'b1;
                    lat_rs_d                = fifo_head[8];
                    lat_data_d              = fifo_head[7:0];
                    lcd_data_d              = BUS_WIDTH'((BUS_WIDTH == 4) ? {4'h0, fifo_head[7:4]}
                                                                          : fifo_head[7:0]);
                    lcd_ctrl_d[LCD_CTRL_RS] = fifo_head[8];
                    lcd_ctrl_d[LCD_CTRL_RW] = 1'b0;
                    second_pending_d        = (BUS_WIDTH == 4);
                    cnt_d                   = SETUP_LOAD;
                    state_d                 = SETUP;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    lcd_enable_d = 1'b1;
                    cnt_d        = PULSE_LOAD;
                    state_d      = PULSE;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    lcd_enable_d = 1'b0;
                    cnt_d        = HOLD_LOAD;
                    state_d      = HOLD;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    if (second_pending) begin
                        second_pending_d = 1'b0;
                        lcd_data_d       = BUS_WIDTH'(lat_data[3:0]);
                        cnt_d            = SETUP_LOAD;
                        state_d          = SETUP;
                    end else begin
                        cnt_d   = is_long_cmd(lat_rs, lat_data) ? CLEAR_LOAD : BUSY_LOAD;
                        state_d = WAIT;
                    end
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_bus_writer.sv
// tb_lcd_bus_writer: self-checking bench for lcd_bus_writer.
// Two instances (8-bit defaults and 4-bit) share clock and reset; a select
// steers the write port to one of them. A timeline model predicts, for each
// accepted byte, its pop cycle, strobe edges, bus values and return to IDLE,
// and every cycle the selected instance's outputs are compared against it.
module tb_lcd_bus_writer;

    localparam int S     = 2;
    localparam int P     = 4;
    localparam int H     = 2;
    localparam int BUSY  = 40;
    localparam int CLEAR = 1600;
    localparam int DEPTH = 4;

    typedef struct {
        int sel;
        int a;
        int p;
        int e;
    } entry_t;

    typedef struct {
        int         sel;
        int         drive;
        int         rise;
        int         fall;
        logic [7:0] val;
        logic [1:0] ctrl;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_valid;
    logic       wr_rs;
    logic [7:0] wr_data;
    int         sel;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    entry_t entries[$];
    beat_t  beats[$];
    int     ovf_cycle[2];

    logic       v8, v4, rdy8, rdy4, e8, e4, b8, b4, o8, o4;
    logic [7:0] d8;
    logic [3:0] d4;
    logic [1:0] c8, c4;

    assign v8 = wr_valid && (sel == 0);
    assign v4 = wr_valid && (sel == 1);

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    lcd_bus_writer dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (v8),
        .wr_ready   (rdy8),
        .wr_rs      (wr_rs),
        .wr_data    (wr_data),
        .lcd_data   (d8),
        .lcd_ctrl   (c8),
        .lcd_enable (e8),
        .busy       (b8),
        .overflow   (o8)
    );

    lcd_bus_writer #(.BUS_WIDTH(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (v4),
        .wr_ready   (rdy4),
        .wr_rs      (wr_rs),
        .wr_data    (wr_data),
        .lcd_data   (d4),
        .lcd_ctrl   (c4),
        .lcd_enable (e4),
        .busy       (b4),
        .overflow   (o4)
    );

    // Append an accepted byte to the timeline: it is popped once the engine
    // has been back in IDLE for an edge, then each beat is S+P+H cycles.
    task automatic addEntry(input int a, input logic rs, input logic [7:0] d);
        entry_t en;
        beat_t  bt;
        int     last_e = 0;
        int     p, w;
        bit     long_cmd;
        foreach (entries[i]) begin
            if (entries[i].sel == sel && entries[i].e > last_e) last_e = entries[i].e;
        end
        p = (a + 1 > last_e + 1) ? a + 1 : last_e + 1;
        bt.sel   = sel;
        bt.ctrl  = {rs, 1'b0};
        bt.drive = p;
        bt.rise  = p + S;
        bt.fall  = bt.rise + P;
        bt.val   = (sel == 0) ? d : {4'h0, d[7:4]};
        beats.push_back(bt);
        if (sel == 1) begin
            bt.drive = bt.fall + H;
            bt.rise  = bt.drive + S;
            bt.fall  = bt.rise + P;
            bt.val   = {4'h0, d[3:0]};
            beats.push_back(bt);
        end
        w        = bt.fall + H;
        long_cmd = !rs && (d == 8'h01 || d == 8'h02 || d == 8'h03);
        en.sel   = sel;
        en.a     = a;
        en.p     = p;
        en.e     = w + (long_cmd ? CLEAR : BUSY);
        entries.push_back(en);
    endtask

    function automatic bit modelReady(input int n);
        int occ = 0;
        foreach (entries[i]) begin
            if (entries[i].sel == sel && entries[i].a <= n && entries[i].p > n) occ++;
        end
        return occ < DEPTH;
    endfunction

    function automatic bit modelEnable(input int n);
        bit en = 1'b0;
        foreach (beats[i]) begin
            if (beats[i].sel == sel && beats[i].rise <= n && n < beats[i].fall) en = 1'b1;
        end
        return en;
    endfunction

    function automatic int lastIdle();
        int last = 0;
        foreach (entries[i]) begin
            if (entries[i].sel == sel && entries[i].e > last) last = entries[i].e;
        end
        return last;
    endfunction

    task automatic clearModel();
        entries.delete();
        beats.delete();
        ovf_cycle[0] = 0;
        ovf_cycle[1] = 0;
    endtask

    task automatic compare(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d, dut %0d)", tag, obs, exp, cyc, sel);
        end
    endtask

    // Compare every output of the selected instance with the model at cycle n.
    task automatic checkOutput(input int n);
        logic [7:0] ed  = 8'h00;
        logic [1:0] ec  = 2'b00;
        logic       eb  = 1'b0;
        logic       eo;
        foreach (entries[i]) begin
            if (entries[i].sel == sel && entries[i].a <= n && entries[i].e > n) eb = 1'b1;
        end
        foreach (beats[i]) begin
            if (beats[i].sel == sel && beats[i].drive <= n) begin
                ed = beats[i].val;
                ec = beats[i].ctrl;
            end
        end
        eo = (ovf_cycle[sel] != 0) && (ovf_cycle[sel] <= n);
        compare("wr_ready",   {7'h0, (sel == 1) ? rdy4 : rdy8}, {7'h0, modelReady(n)});
        compare("busy",       {7'h0, (sel == 1) ? b4 : b8},     {7'h0, eb});
        compare("lcd_enable", {7'h0, (sel == 1) ? e4 : e8},     {7'h0, modelEnable(n)});
        compare("lcd_data",   (sel == 1) ? {4'h0, d4} : d8,     ed);
        compare("lcd_ctrl",   {6'h0, (sel == 1) ? c4 : c8},     {6'h0, ec});
        compare("overflow",   {7'h0, (sel == 1) ? o4 : o8},     {7'h0, eo});
    endtask

    // One cycle: check outputs, drive the write port, advance to next negedge.
    task automatic applyStimulus(input logic v, input logic rs, input logic [7:0] d);
        int n = cyc;
        bit rdy;
        rdy = modelReady(n);
        checkOutput(n);
        wr_valid = v;
        wr_rs    = rs;
        wr_data  = d;
        if (v && rdy) begin
            addEntry(n + 1, rs, d);
        end else if (v && ovf_cycle[sel] == 0) begin
            ovf_cycle[sel] = n + 1;
        end
        @(negedge clk);
    endtask

    task automatic writeWhenReady(input logic rs, input logic [7:0] d);
        int tries = 0;
        while (!modelReady(cyc) && tries < 5000) begin
            applyStimulus(1'b0, 1'b0, 8'h00);
            tries++;
        end
        compare("ready_timeout", {7'h0, tries < 5000}, 8'h01);
        applyStimulus(1'b1, rs, d);
    endtask

    task automatic drain();
        int last = lastIdle();
        while (cyc <= last + 2) applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    task automatic idleCycles(input int k);
        for (int i = 0; i < k; i++) applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        int target;
        wr_valid = 1'b0;
        wr_rs    = 1'b0;
        wr_data  = 8'h00;
        sel      = 0;
        clearModel();
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        $display("[TB] reset values");
        sel = 1;
        checkOutput(cyc);
        sel = 0;
        idleCycles(2);

        $display("[TB] 8-bit single data write");
        applyStimulus(1'b1, 1'b1, 8'h41);
        drain();

        $display("[TB] 4-bit two-nibble write");
        sel = 1;
        applyStimulus(1'b1, 1'b1, 8'hA5);
        drain();
        sel = 0;

        $display("[TB] clear / home / normal command waits");
        applyStimulus(1'b1, 1'b0, 8'h01);
        drain();
        applyStimulus(1'b1, 1'b0, 8'h03);
        drain();
        applyStimulus(1'b1, 1'b0, 8'h0C);
        drain();

        $display("[TB] held-valid burst with overflow");
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'(i[0]), 8'($urandom_range(255)));
        drain();

        $display("[TB] reset mid-pulse with queued entries");
        for (int i = 0; i < 3; i++) writeWhenReady(1'b1, 8'($urandom_range(255)));
        for (int i = 0; i < 200 && !modelEnable(cyc); i++) applyStimulus(1'b0, 1'b0, 8'h00);
        compare("pulse_reached", {7'h0, e8}, 8'h01);
        rst_n = 1'b1;
        #1;
        compare("rst_enable", {7'h0, e8}, 8'h00);
        compare("rst_busy",   {7'h0, b8}, 8'h00);
        compare("rst_ready",  {7'h0, rdy8}, 8'h01);
        clearModel();
        @(negedge clk);
        rst_n = 1'b0;
        idleCycles(20);

        $display("[TB] ready-respecting burst of six");
        for (int i = 0; i < 6; i++) writeWhenReady(1'b1, 8'(8'h30 + i));
        drain();

        $display("[TB] push on the pop edge with two queued");
        for (int i = 0; i < 3; i++) writeWhenReady(1'b1, 8'($urandom_range(255)));
        target = entries[entries.size() - 2].p - 1;
        while (cyc < target) applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'h7E);
        drain();

        $display("[TB] randomized traffic");
        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int i = 0; i < 8; i++) begin
                idleCycles($urandom_range(0, 30));
                writeWhenReady(1'($urandom_range(1)), 8'($urandom_range(255)));
            end
            drain();
        end
        sel = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
